// File: rtl/search_arbiter_pkg.sv
// Shared types for the search arbiter: FSM states, response record and the id-width helper.
package search_pkg;

  // Address width of the shared binary-search engine; the response record is sized to it.
  localparam int unsigned EngAddrW = 5;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StResp,
    StRelease
  } state_e;

  typedef struct packed {
    logic                found;
    logic [EngAddrW-1:0] addr;
    logic                timeout;
  } resp_t;

  // Width of a requester index; never zero so single-bit ports stay legal.
  function automatic int unsigned id_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/search_arbiter_if.sv
// Requester and engine signals of the search arbiter, grouped as one bus.
// slave: the arbiter side; master: requesters plus the engine.
interface search_arbiter_if
  import search_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = EngAddrW
);
  localparam int unsigned IdW = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic                          resp_valid;
  logic [IdW-1:0]                resp_id;
  logic                          resp_found;
  logic [ADDR_WIDTH-1:0]         resp_addr;
  logic                          resp_timeout;
  logic                          eng_s;
  logic [DATA_WIDTH-1:0]         eng_data;
  logic                          eng_done;
  logic                          eng_found;
  logic [ADDR_WIDTH-1:0]         eng_addr;

  modport slave (
    input  req, req_data, eng_done, eng_found, eng_addr,
    output grant, busy, resp_valid, resp_id, resp_found, resp_addr, resp_timeout,
           eng_s, eng_data
  );

  modport master (
    output req, req_data, eng_done, eng_found, eng_addr,
    input  grant, busy, resp_valid, resp_id, resp_found, resp_addr, resp_timeout,
           eng_s, eng_data
  );

endinterface

// File: rtl/search_arbiter_rr_pick.sv
// Rotating-priority picker: first set request bit searching upward from ptr+1 (mod NUM_REQ).
module rr_pick
  import search_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdW    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdW-1:0]     ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IdW-1:0]     id,
  output logic               any
);

  // Walk candidates in priority order; the previous winner (ptr) is visited last.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    onehot = '0;
    id     = '0;
    any    = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!any && req[IdW'(idx)]) begin
        any                 = 1'b1;
        onehot[IdW'(idx)]   = 1'b1;
        id                  = IdW'(idx);
      end
    end
  end

endmodule

// File: rtl/search_arbiter.sv
// Round-robin arbiter sharing one binary-search engine among NUM_REQ requesters.
// Optional watchdog on the engine wait: define SEARCH_ARB_TIMEOUT_EN.
module search_arbiter
  import search_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = EngAddrW
`ifdef SEARCH_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input logic             clk,
  input logic             reset,
  search_arbiter_if.slave bus
);

  localparam int unsigned IdW = id_w(NUM_REQ);

  state_e                state_q, state_d;
  logic [IdW-1:0]        ptr_q, ptr_d;
  logic [IdW-1:0]        id_q, id_d;
  logic [IdW-1:0]        resp_id_q, resp_id_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  resp_t                 resp_q, resp_d;

  logic [DATA_WIDTH-1:0] keys [NUM_REQ];
  logic [NUM_REQ-1:0]    pick_onehot;
  logic [IdW-1:0]        pick_id;
  logic                  pick_any;
  logic                  timed_out;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_keys
    assign keys[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .id     (pick_id),
    .any    (pick_any)
  );

`ifdef SEARCH_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  // Watchdog: cleared in LAUNCH, counts every WAIT cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StLaunch) begin
      cnt_d = '0;
    end else if (state_q == StWait) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Watchdog register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign timed_out = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT_CYCLES));
`else
  assign timed_out = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= IdW'(NUM_REQ - 1);
      id_q      <= '0;
      resp_id_q <= '0;
      grant_q   <= '0;
      data_q    <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      resp_id_q <= resp_id_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      resp_q    <= resp_d;
    end
  end

  // Next-state: pick in IDLE, capture the engine result when WAIT ends.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    resp_id_d = resp_id_q;
    grant_d   = grant_q;
    data_d    = data_q;
    resp_d    = resp_q;
    case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d = StLaunch;
          ptr_d   = pick_id;
          id_d    = pick_id;
          grant_d = pick_onehot;
          data_d  = keys[pick_id];
        end
      end
      StLaunch: state_d = StWait;
      StWait: begin
        if (bus.eng_done) begin
          state_d   = StResp;
          resp_id_d = id_q;
          resp_d    = '{found: bus.eng_found, addr: bus.eng_addr, timeout: 1'b0};
        end else if (timed_out) begin
          state_d   = StResp;
          resp_id_d = id_q;
          resp_d    = '{found: 1'b0, addr: '0, timeout: 1'b1};
        end
      end
      StResp: state_d = StRelease;
      StRelease: begin
        // Engine must drop done before it can be re-armed.
        if (!bus.eng_done) begin
          state_d = StIdle;
          grant_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state and held registers.
  always_comb begin
    bus.eng_s        = (state_q == StWait);
    bus.busy         = (state_q != StIdle);
    bus.resp_valid   = (state_q == StResp);
    bus.grant        = grant_q;
    bus.eng_data     = data_q;
    bus.resp_id      = resp_id_q;
    bus.resp_found   = resp_q.found;
    bus.resp_addr    = resp_q.addr;
    bus.resp_timeout = resp_q.timeout;
  end

endmodule

// File: tb/tb_search_arbiter.sv
// Scoreboard bench for search_arbiter with a behavioural binary-search engine (RAM[i] = i).
module tb_search_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  search_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(5)) sif ();

  search_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(5)
`ifdef SEARCH_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- engine model ----------------
  localparam int SearchLat = 4;
  logic [7:0] ram [32];
  logic [7:0] eng_key;
  int         eng_cnt;
  int         hold_cnt;
  int         done_hold = 0;
  bit         stuck = 1'b0;

  initial for (int i = 0; i < 32; i++) ram[i] = 8'(i);

  function automatic int ram_find(input logic [7:0] key);
    for (int i = 0; i < 32; i++) if (ram[i] == key) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      sif.eng_done  <= 1'b0;
      sif.eng_found <= 1'b0;
      sif.eng_addr  <= '0;
      eng_cnt       <= 0;
      hold_cnt      <= 0;
    end else if (sif.eng_s) begin
      if (!sif.eng_done) begin
        if (eng_cnt == SearchLat - 1 && !stuck) begin
          sif.eng_done  <= 1'b1;
          sif.eng_found <= (ram_find(eng_key) >= 0);
          sif.eng_addr  <= (ram_find(eng_key) >= 0) ? 5'(ram_find(eng_key)) : 5'd0;
        end
        eng_cnt <= eng_cnt + 1;
      end
      hold_cnt <= done_hold;
    end else begin
      eng_key <= sif.eng_data;
      eng_cnt <= 0;
      if (sif.eng_done && hold_cnt != 0) hold_cnt <= hold_cnt - 1;
      else sif.eng_done <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int id;
    int found;
    int addr;
    int timeout;
  } exp_t;
  exp_t sb[$];

  task automatic expect_resp(input int id, input int found, input int addr, input int tmo);
    exp_t e;
    e = '{id: id, found: found, addr: addr, timeout: tmo};
    sb.push_back(e);
  endtask

  // Monitor: pops an expectation on every response strobe; grant sanity every cycle.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("grant_onehot0", 32'($countones(sif.grant) <= 1), 32'd1);
      if (!sif.busy) check("grant_idle", 32'(sif.grant), 32'd0);
      if (sif.resp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_id",      32'(sif.resp_id),      32'(e.id));
          check("resp_found",   32'(sif.resp_found),   32'(e.found));
          check("resp_addr",    32'(sif.resp_addr),    32'(e.addr));
          check("resp_timeout", 32'(sif.resp_timeout), 32'(e.timeout));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] keys [4];

  task automatic drive(input logic [3:0] r);
    sif.req_data = {keys[3], keys[2], keys[1], keys[0]};
    sif.req      = r;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sif.resp_valid && n < 200);
    if (!sif.resp_valid) check("resp_wait_bound", 32'd0, 32'd1);
  endtask

  task automatic check_release(input int exp_len);
    int rel;
    rel = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 0) check("resp_one_cycle", 32'(sif.resp_valid), 32'd0);
      if (!sif.busy) break;
      check("release_eng_s", 32'(sif.eng_s), 32'd0);
      rel++;
    end
    check("release_len", 32'(rel), 32'(exp_len));
  endtask

  // Single request: checks LAUNCH and first WAIT cycle, then response and release.
  task automatic single(input logic [1:0] id, input logic [7:0] key, input int rel_len);
    int n;
    keys[id] = key;
    drive(4'b0001 << id);
    @(negedge clk);
    check("launch_busy",  32'(sif.busy),     32'd1);
    check("launch_eng_s", 32'(sif.eng_s),    32'd0);
    check("launch_grant", 32'(sif.grant),    32'd1 << id);
    check("launch_data",  32'(sif.eng_data), 32'(key));
    @(negedge clk);
    check("wait_eng_s",   32'(sif.eng_s),    32'd1);
    wait_resp(n);
    drive(4'b0000);
    check_release(rel_len);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    keys  = '{default: 8'd0};
    drive(4'b0000);

    // 1: reset then idle
    repeat (2) @(negedge clk);
    check("rst_grant",      32'(sif.grant),        32'd0);
    check("rst_busy",       32'(sif.busy),         32'd0);
    check("rst_resp_valid", 32'(sif.resp_valid),   32'd0);
    check("rst_resp_id",    32'(sif.resp_id),      32'd0);
    check("rst_resp_found", 32'(sif.resp_found),   32'd0);
    check("rst_resp_addr",  32'(sif.resp_addr),    32'd0);
    check("rst_timeout",    32'(sif.resp_timeout), 32'd0);
    check("rst_eng_data",   32'(sif.eng_data),     32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_eng_s", 32'(sif.eng_s), 32'd0);
      check("idle_busy",  32'(sif.busy),  32'd0);
    end

    // 2: single search, key 17 found at 17 by requester 2
    expect_resp(2, 1, 17, 0);
    single(2'd2, 8'd17, 1);

    // 3: not found, engine keeps done high 3 extra cycles after eng_s drops
    done_hold = 3;
    expect_resp(0, 0, 0, 0);
    single(2'd0, 8'd200, 4);
    check("after_release_busy", 32'(sif.busy), 32'd0);
    done_hold = 0;

    // 4: round robin from reset, all requesters held
    do_reset(2);
    keys = '{8'd3, 8'd10, 8'd25, 8'd31};
    expect_resp(0, 1, 3, 0);
    expect_resp(1, 1, 10, 0);
    expect_resp(2, 1, 25, 0);
    expect_resp(3, 1, 31, 0);
    expect_resp(0, 1, 3, 0);
    drive(4'b1111);
    for (int k = 0; k < 5; k++) begin
      wait_resp(n);
      if (k == 4) drive(4'b0000);
      check_release(1);
    end

    // 5: reset 3 cycles into WAIT, then serve from requester 0
    keys[1] = 8'd5;
    drive(4'b0010);
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("pre_rst_eng_s", 32'(sif.eng_s), 32'd1);
    reset = 1'b1;
    drive(4'b0000);
    @(negedge clk);
    check("midrst_eng_s",      32'(sif.eng_s),      32'd0);
    check("midrst_grant",      32'(sif.grant),      32'd0);
    check("midrst_busy",       32'(sif.busy),       32'd0);
    check("midrst_resp_valid", 32'(sif.resp_valid), 32'd0);
    reset = 1'b0;
    keys[0] = 8'd7;
    keys[3] = 8'd20;
    expect_resp(0, 1, 7, 0);
    expect_resp(3, 1, 20, 0);
    drive(4'b1001);
    wait_resp(n);
    drive(4'b1000);
    check_release(1);
    wait_resp(n);
    drive(4'b0000);
    check_release(1);

    // 6: engine never completes
    stuck   = 1'b1;
    keys[2] = 8'd9;
`ifdef SEARCH_ARB_TIMEOUT_EN
    expect_resp(2, 0, 0, 1);
    drive(4'b0100);
    @(negedge clk);
    wait_resp(n);
    check("timeout_latency", 32'(n), 32'd10);
    drive(4'b0000);
    check_release(1);
`else
    drive(4'b0100);
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sif.busy && sif.eng_s) n++;
    end
    check("stuck_busy_cycles", 32'(n), 32'd100);
    drive(4'b0000);
    do_reset(2);
`endif
    stuck = 1'b0;

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
